alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, registered ALU for the 16-bit CPU datapath. It generalises the 1-bit ALU slice to a `WIDTH`-bit unit with registered outputs and a Start/Done handshake. Logic and arithmetic ops complete in one clock. Shifts run iteratively, one bit per clock, unless fast shift is compiled in. It sits between the register-file read ports and the writeback mux; the control unit stalls on `Busy`.

## Interface
- `WIDTH`, 16, operand/result width; must be ≥ 2 and a power of two.
- `SHW` (localparam), $clog2(WIDTH), shift-amount width.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-high (already decided).
- `Start` in 1: request; sampled only in IDLE.
- `Op` in 3: 000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD, 101 SUB, 110 SRA, 111 SLL.
- `A` in WIDTH: operand A; shift source for shifts.
- `B` in WIDTH: operand B; `B[SHW-1:0]` is the shift amount for shifts.
- `Busy` out 1: high while a shift iterates.
- `Done` out 1: one-cycle pulse when `Result` and flags update.
- `Result` out WIDTH: registered result; holds until the next completion.
- `CarryOut` out 1: adder carry for ADD/SUB; 0 otherwise.
- `Overflow` out 1: signed overflow for ADD/SUB; 0 otherwise.
- `Zero` out 1: `Result == 0`, registered with `Result`.

## Operation
- States:
  - IDLE: accepts `Start`.
  - SHIFT: iterating.
- Accept: `Start` high at a rising edge while in IDLE. `A`, `B` and `Op` are captured at that edge. `Start` while `Busy` is ignored and not queued.
- Non-shift ops, and shifts with amount 0: `Result` and flags are written at the accept edge. `Done` is high the following cycle. The unit stays in IDLE.
- Arithmetic rules:
  - ADD: `A + B`.
  - SUB: `A + ~B + 1`.
  - `CarryOut` is the carry out of the MSB. For SUB, 1 means no borrow (`A >= B` unsigned).
  - `Overflow` = operand signs are equal (after B inversion for SUB) and the result sign differs.
  - Result wraps modulo 2^WIDTH.
- SLT: signed compare. `Result = {0…, (A < B)}`. `CarryOut = Overflow = 0`.
- SRA and SLL with amount k > 0:
  - Accept edge: load the work register with `A` and the counter with k. Go to SHIFT and set `Busy = 1`.
  - Each following edge shifts the work register by 1 and decrements the counter. SRA replicates the MSB; SLL fills with 0.
  - On the edge where the counter is 1: the final shift is written to `Result`, `Zero` updates, `Busy` goes to 0, `Done` goes to 1 and the state returns to IDLE.
  - `CarryOut = Overflow = 0`.
- Back-to-back: a new `Start` is accepted in the cycle `Done` is high.

## Timing
- Reset values: state IDLE; `Busy`, `Done`, `CarryOut` and `Overflow` = 0; `Result` = 0; `Zero` = 1. Work register and counter = 0.
- Latency (accept edge to the edge that writes `Result`):
  - Non-shift ops: 0 edges, so `Done` is visible 1 cycle after accept.
  - Shift by k: k edges.
- `Busy` is high for exactly k cycles per shift. `Done` is never high while `Busy` is high.
- `Reset` asserted mid-shift: the shift is aborted immediately and all outputs return to reset values. No `Done` is produced.
- Maximum shift is WIDTH−1 (e.g. 15 at WIDTH 16). Upper bits of `B` are ignored for shifts.

## Configuration
- `ALU_FASTSHIFT_EN` defined: SRA and SLL use a combinational barrel shifter and complete like non-shift ops. SHIFT is never entered and `Busy` stays 0.
- `ALU_FASTSHIFT_EN` undefined: iterative shifting as described above. This is the area-minimal default.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants (`OP_AND` … `OP_SLL`),
  - state encoding (`S_IDLE`, `S_SHIFT`),
  - flag bit positions.
- One sub-module: `alu_addsub`, a combinational WIDTH-bit adder with invert-B and carry-in. It returns sum, carry and overflow and is shared by ADD, SUB and SLT.

## Test plan
1. ADD, `A = 0x7FFF`, `B = 0x0001` -> `Result = 0x8000`, `Overflow = 1`, `CarryOut = 0`, `Zero = 0`, `Done` 1 cycle after accept.
2. SUB, `A = 0x0005`, `B = 0x0005` -> `Result = 0x0000`, `Zero = 1`, `CarryOut = 1`, `Overflow = 0`.
3. SLT, `A = 0xFFFF`, `B = 0x0001` -> `Result = 0x0001`. Then `A = 0x0001`, `B = 0xFFFF` -> `Result = 0x0000`, `Zero = 1`.
4. SRA, `A = 0x8000`, `B = 0x0004` -> `Result = 0xF800` after 4 edges with `Busy` high for 4 cycles. An ADD `Start` pulsed during `Busy` is ignored. With `ALU_FASTSHIFT_EN`: `Done` after 1 cycle and `Busy` stays 0.
5. SLL, `A = 0x0001`, `B = 0x0013` -> `Result = 0x0008` (amount 3). SLL with `B = 0x0010` (amount 0) -> `Result = 0x0001` in one cycle, no `Busy`.
6. `Reset` asserted 2 cycles into SRA with `A = 0x8000`, `B = 0x000F` -> `Busy = 0`, `Done = 0`, `Result = 0`, `Zero = 1` immediately. After release, ADD `0x0002 + 0x0003` -> `0x0005`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the iterative ALU: opcodes, FSM state encoding and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_SLT = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_W = 3;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder with optional B inversion and carry-in; shared by ADD, SUB and SLT.
module alu_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inv_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = inv_b ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(cin);
  // Same-sign operands producing an opposite-sign sum.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_iter.sv
// Registered ALU with Start/Done handshake; shifts iterate one bit per clock
// unless ALU_FASTSHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t            state;
  logic [WIDTH-1:0]  work;
  logic [SHW-1:0]    cnt;
  logic              sra_q;
  logic [FLAG_W-1:0] flags;

  logic [SHW-1:0]    amt;
  logic              sub;
  logic [WIDTH-1:0]  sum;
  logic              cy;
  logic              ov;
  logic [WIDTH-1:0]  res;
  logic              res_cy;
  logic              res_ov;
  logic              shift_start;
  logic [WIDTH-1:0]  work_next;

  assign amt = B[SHW-1:0];
  assign sub = (Op == OP_SUB) || (Op == OP_SLT);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (A),
    .b        (B),
    .inv_b    (sub),
    .cin      (sub),
    .sum      (sum),
    .carry    (cy),
    .overflow (ov)
  );

  // Single-cycle result; shifts by a non-zero amount hand off to the iterator.
  always_comb begin
    res         = '0;
    res_cy      = 1'b0;
    res_ov      = 1'b0;
    shift_start = 1'b0;
    case (Op)
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_ADD, OP_SUB: begin
        res    = sum;
        res_cy = cy;
        res_ov = ov;
      end
      OP_SLT: res = WIDTH'(sum[WIDTH-1] ^ ov);
`ifdef ALU_FASTSHIFT_EN
      OP_SRA: res = WIDTH'($signed(A) >>> amt);
      OP_SLL: res = A << amt;
`else
      OP_SRA, OP_SLL: begin
        res         = A;
        shift_start = (amt != '0);
      end
`endif
      default: res = '0;
    endcase
  end

  assign work_next = sra_q ? {work[WIDTH-1], work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};

  assign CarryOut = flags[FLAG_C];
  assign Overflow = flags[FLAG_V];
  assign Zero     = flags[FLAG_Z];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= S_IDLE;
      work          <= '0;
      cnt           <= '0;
      sra_q         <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Result        <= '0;
      flags         <= '0;
      flags[FLAG_Z] <= 1'b1;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (shift_start) begin
              work  <= A;
              cnt   <= amt;
              sra_q <= (Op == OP_SRA);
              Busy  <= 1'b1;
              state <= S_SHIFT;
            end else begin
              Result        <= res;
              flags[FLAG_C] <= res_cy;
              flags[FLAG_V] <= res_ov;
              flags[FLAG_Z] <= (res == '0);
              Done          <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          work <= work_next;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            Result        <= work_next;
            flags[FLAG_C] <= 1'b0;
            flags[FLAG_V] <= 1'b0;
            flags[FLAG_Z] <= (work_next == '0);
            Busy          <= 1'b0;
            Done          <= 1'b1;
            state         <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: driver pushes model results, monitor pops on every Done.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W   = 16;
  localparam int SHW = 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    int           lat;
    int           cyc;
  } exp_t;

  logic         Clock;
  logic         Reset;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         CarryOut;
  logic         Overflow;
  logic         Zero;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  alu_iter #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .CarryOut (CarryOut),
    .Overflow (Overflow),
    .Zero     (Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ua, ub, sa, sb, s, k, smax, smin;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    k    = ub % W;
    smax = (1 << (W-1)) - 1;
    smin = -(1 << (W-1));
    e.r = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 0; e.cyc = 0;
    case (op)
      OP_AND: e.r = a & b;
      OP_OR:  e.r = a | b;
      OP_XOR: e.r = a ^ b;
      OP_ADD: begin
        s   = ua + ub;
        e.r = W'(s);
        e.c = (s >= (1 << W));
        s   = sa + sb;
        e.v = (s > smax) || (s < smin);
      end
      OP_SUB: begin
        e.r = W'(ua - ub);
        e.c = (ua >= ub);
        s   = sa - sb;
        e.v = (s > smax) || (s < smin);
      end
      OP_SLT: e.r = (sa < sb) ? W'(1) : W'(0);
      OP_SRA: e.r = W'(sa >>> k);
      OP_SLL: e.r = W'(ua << k);
      default: e.r = '0;
    endcase
`ifndef ALU_FASTSHIFT_EN
    if (op == OP_SRA || op == OP_SLL) e.lat = k;
`endif
    e.z = (e.r == '0);
    return e;
  endfunction

  // Issue one op; optionally pulse an ADD Start while the shift is busy (must be ignored).
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse);
    exp_t e;
    e     = model(op, a, b);
    e.cyc = cyc + 1 + e.lat;
    q.push_back(e);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    if (pulse && e.lat > 0) begin
      Start = 1'b1; Op = OP_ADD; A = W'($urandom); B = W'($urandom);
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (e.lat - 1) begin @(posedge Clock); #1; end
    end else begin
      repeat (e.lat) begin @(posedge Clock); #1; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   32'(Busy),     32'h0);
    check({tag, "_done"},   32'(Done),     32'h0);
    check({tag, "_result"}, 32'(Result),   32'h0);
    check({tag, "_zero"},   32'(Zero),     32'h1);
    check({tag, "_carry"},  32'(CarryOut), 32'h0);
    check({tag, "_ovf"},    32'(Overflow), 32'h0);
  endtask

  // Monitor: compare every Done against the head of the scoreboard.
  initial begin : monitor
    int   bc;
    exp_t e;
    bc = 0;
    forever begin
      @(posedge Clock); #1;
      if (Reset) begin
        bc = 0;
      end else if (Done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: Done high with Result %0h and nothing outstanding (cycle %0d)", Result, cyc);
        end else begin
          e = q.pop_front();
          check("result",       32'(Result),   32'(e.r));
          check("carry",        32'(CarryOut), 32'(e.c));
          check("overflow",     32'(Overflow), 32'(e.v));
          check("zero",         32'(Zero),     32'(e.z));
          check("done_cycle",   32'(cyc),      32'(e.cyc));
          check("busy_cycles",  32'(bc),       32'(e.lat));
          check("busy_at_done", 32'(Busy),     32'h0);
        end
        bc = 0;
      end else if (Busy) begin
        bc++;
      end
    end
  end

  logic [W-1:0] corner [5];

  initial begin : driver
    logic [2:0]   op;
    logic [W-1:0] a, b;
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
    corner[3] = 16'h7FFF; corner[4] = 16'h0001;
    Reset = 1'b1; Start = 1'b0; Op = OP_AND; A = '0; B = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_reset_outputs("reset");
    #2 Reset = 1'b0;
    @(posedge Clock); #1;

    do_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
    do_op(OP_SUB, 16'h0005, 16'h0005, 1'b0);
    do_op(OP_SLT, 16'hFFFF, 16'h0001, 1'b0);
    do_op(OP_SLT, 16'h0001, 16'hFFFF, 1'b0);
    do_op(OP_SRA, 16'h8000, 16'h0004, 1'b1);
    do_op(OP_SLL, 16'h0001, 16'h0013, 1'b0);
    do_op(OP_SLL, 16'h0001, 16'h0010, 1'b0);
    do_op(OP_SRA, 16'h8001, 16'h000F, 1'b1);
    do_op(OP_SUB, 16'h0000, 16'h0001, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      do_op(op, a, b, 1'($urandom_range(0, 1)));
    end

    // Abort a long shift with an asynchronous reset.
    Op = OP_SRA; A = 16'h8000; B = 16'h000F; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge Clock);
    #3 Reset = 1'b0;
    @(posedge Clock); #1;
    do_op(OP_ADD, 16'h0002, 16'h0003, 1'b0);

    repeat (W + 4) begin @(posedge Clock); #1; end
    check("pending_expected", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
